// File: rtl/ebpc_out_packer_if.sv
// Stream bundle around the output packer: narrow decoded-word input side
// and wide byte-strobed bus output side, named after the block's ports.
interface ebpc_out_packer_if #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_LANES = 4
);
  localparam int unsigned OUT_W = DATA_W * NUM_LANES;

  logic [DATA_W-1:0]    data_i;
  logic                 last_i;
  logic                 vld_i;
  logic                 rdy_o;
  logic [OUT_W-1:0]     data_o;
  logic [NUM_LANES-1:0] strb_o;
  logic                 last_o;
  logic                 vld_o;
  logic                 rdy_i;

  modport slave (
    input  data_i, last_i, vld_i, rdy_i,
    output rdy_o, data_o, strb_o, last_o, vld_o
  );

  modport master (
    output data_i, last_i, vld_i, rdy_i,
    input  rdy_o, data_o, strb_o, last_o, vld_o
  );
endinterface

// File: rtl/ebpc_out_packer.sv
// Packs DATA_W decoder words into NUM_LANES-wide bus words; a packet's final
// partial word is flushed with a contiguous low strobe mask and last_o.
module ebpc_out_packer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_LANES = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  ebpc_out_packer_if.slave    bus
);
  localparam int unsigned OUT_W = DATA_W * NUM_LANES;
  localparam int unsigned BUF_W = DATA_W * (NUM_LANES - 1);
  localparam int unsigned CW    = $clog2(NUM_LANES);
  localparam logic [CW-1:0] CNT_MAX = CW'(NUM_LANES - 1);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BUF_W-1:0]     buf_q, buf_d;
  logic [OUT_W-1:0]     data_q, data_d;
  logic [NUM_LANES-1:0] strb_q, strb_d;
  logic                 last_q, last_d;
  logic                 vld_q, vld_d;

  logic rdy;
  logic in_fire;
  logic out_fire;
  logic complete;

  // Ready depends only on the output register, never on vld_i.
  assign rdy      = ~vld_q | bus.rdy_i;
  assign in_fire  = bus.vld_i & rdy;
  assign out_fire = vld_q & bus.rdy_i;
  assign complete = (cnt_q == CNT_MAX) | bus.last_i;

  always_comb begin
    cnt_d  = cnt_q;
    buf_d  = buf_q;
    data_d = data_q;
    strb_d = strb_q;
    last_d = last_q;
    vld_d  = vld_q;

    if (out_fire) begin
      vld_d = 1'b0;
    end

    if (in_fire) begin
      if (complete) begin
        data_d = '0;
        strb_d = '0;
        for (int unsigned k = 0; k < NUM_LANES - 1; k++) begin
          if (CW'(k) < cnt_q) begin
            data_d[k*DATA_W +: DATA_W] = buf_q[k*DATA_W +: DATA_W];
          end
        end
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
          if (CW'(k) == cnt_q) begin
            data_d[k*DATA_W +: DATA_W] = bus.data_i;
          end
          if (CW'(k) <= cnt_q) begin
            strb_d[k] = 1'b1;
          end
        end
        last_d = bus.last_i;
        vld_d  = 1'b1;
        cnt_d  = '0;
        buf_d  = '0;
      end else begin
        for (int unsigned k = 0; k < NUM_LANES - 1; k++) begin
          if (CW'(k) == cnt_q) begin
            buf_d[k*DATA_W +: DATA_W] = bus.data_i;
          end
        end
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      buf_q  <= '0;
      data_q <= '0;
      strb_q <= '0;
      last_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      buf_q  <= buf_d;
      data_q <= data_d;
      strb_q <= strb_d;
      last_q <= last_d;
      vld_q  <= vld_d;
    end
  end

  assign bus.rdy_o  = rdy;
  assign bus.data_o = data_q;
  assign bus.strb_o = strb_q;
  assign bus.last_o = last_q;
  assign bus.vld_o  = vld_q;

endmodule

// File: tb/tb_ebpc_out_packer.sv
// Directed bench for ebpc_out_packer: scoreboard of expected bus words plus
// constant checks on the captured output log for each scenario.
module tb_ebpc_out_packer;
  localparam int unsigned DW = 8;
  localparam int unsigned NL = 4;
  localparam int unsigned OW = DW * NL;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [NL-1:0] strb;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ebpc_out_packer_if #(.DATA_W(DW), .NUM_LANES(NL)) bus ();

  ebpc_out_packer #(.DATA_W(DW), .NUM_LANES(NL)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  beat_t sb[$];
  beat_t obs[$];
  int n_cmp = 0;
  int n_bad = 0;

  int unsigned   mcnt = 0;
  logic [OW-1:0] macc = '0;

  int    stall_left = 0;
  bit    stall_arm  = 0;
  bit    stalling   = 0;
  bit    thru       = 0;
  beat_t held;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b.data = bus.data_o;
    b.strb = bus.strb_o;
    b.last = bus.last_o;
    return b;
  endfunction

  // Sink side: drives rdy_i at negedge, samples outputs shortly after.
  always @(negedge clk) begin
    if (stall_arm && bus.vld_o) begin
      stall_left = 5;
      stall_arm  = 0;
      stalling   = 1;
      held       = cur_beat();
    end
    bus.rdy_i = (stall_left == 0);
    if (stall_left > 0) stall_left--;
    if (bus.rdy_i) stalling = 0;
    #2;
    if (stalling) begin
      check("stall_rdy_o", 64'(bus.rdy_o), 64'(1'b0));
      check("stall_hold", 64'(cur_beat()), 64'(held));
    end
    if (thru) check("thru_rdy_o", 64'(bus.rdy_o), 64'(1'b1));
    if (bus.vld_o && bus.rdy_i) begin
      check("sb_nonempty", 64'(sb.size() > 0), 64'(1'b1));
      if (sb.size() > 0) check("sb_word", 64'(cur_beat()), 64'(sb.pop_front()));
      obs.push_back(cur_beat());
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic l);
    bit acc = 0;
    beat_t e;
    @(negedge clk);
    bus.data_i = d;
    bus.last_i = l;
    bus.vld_i  = 1'b1;
    for (int w = 0; w < 100; w++) begin
      #1;
      if (bus.rdy_o === 1'b1) begin
        acc = 1;
        break;
      end
      @(negedge clk);
    end
    check("send_accept", 64'(acc), 64'(1'b1));
    if (acc) begin
      @(posedge clk);
      macc[mcnt*DW +: DW] = d;
      if (l || mcnt == NL - 1) begin
        e.data = macc;
        e.strb = NL'((1 << (mcnt + 1)) - 1);
        e.last = l;
        sb.push_back(e);
        macc = '0;
        mcnt = 0;
      end else begin
        mcnt++;
      end
    end
    #1;
    bus.vld_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && (sb.size() != 0 || bus.vld_o === 1'b1); i++) @(negedge clk);
    #3;
    check(tag, 64'(sb.size()), 64'(0));
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [OW-1:0] d,
                          input logic [NL-1:0] s, input logic l);
    beat_t e;
    e.data = d;
    e.strb = s;
    e.last = l;
    check({tag, "_present"}, 64'(obs.size() > idx), 64'(1'b1));
    if (obs.size() > idx) check(tag, 64'(obs[idx]), 64'(e));
  endtask

  initial begin
    int n_last1;
    bus.data_i = '0;
    bus.last_i = 1'b0;
    bus.vld_i  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld_o", 64'(bus.vld_o), 64'(1'b0));
    check("rst_last_o", 64'(bus.last_o), 64'(1'b0));
    check("rst_data_o", 64'(bus.data_o), 64'(0));
    check("rst_strb_o", 64'(bus.strb_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rdy_o", 64'(bus.rdy_o), 64'(1'b1));

    // Single full word, latency and one-cycle valid pulse
    obs.delete();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b1);
    check("t1_latency", 64'(bus.vld_o), 64'(1'b1));
    @(posedge clk);
    #1;
    check("t1_pulse", 64'(bus.vld_o), 64'(1'b0));
    drain("t1_drain");
    chk_beat("t1_word", 0, 32'h04030201, 4'hF, 1'b1);
    check("t1_count", 64'(obs.size()), 64'(1));

    // Partial flush
    obs.delete();
    for (int i = 1; i <= 6; i++) send(DW'(i), i == 6);
    drain("t2_drain");
    chk_beat("t2_word0", 0, 32'h04030201, 4'hF, 1'b0);
    chk_beat("t2_word1", 1, 32'h00000605, 4'h3, 1'b1);

    // Single-word packet, then a 3-word packet with no stale lanes
    obs.delete();
    send(8'hAA, 1'b1);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    drain("t3_drain");
    chk_beat("t3_word0", 0, 32'h000000AA, 4'h1, 1'b1);
    chk_beat("t3_word1", 1, 32'h00332211, 4'h7, 1'b1);

    // Backpressure: 5-cycle stall after first output valid
    obs.delete();
    stall_arm = 1;
    for (int i = 1; i <= 8; i++) send(DW'(i), i == 8);
    drain("t4_drain");
    check("t4_stall_seen", 64'(stall_arm), 64'(1'b0));
    chk_beat("t4_word0", 0, 32'h04030201, 4'hF, 1'b0);
    chk_beat("t4_word1", 1, 32'h08070605, 4'hF, 1'b1);
    check("t4_count", 64'(obs.size()), 64'(2));

    // Throughput: 11 packets of 37 random words, back to back
    obs.delete();
    thru = 1;
    for (int i = 0; i < 407; i++) send(DW'($urandom), (i % 37) == 36);
    drain("t5_drain");
    thru = 0;
    n_last1 = 0;
    foreach (obs[i]) if (obs[i].last && obs[i].strb == 4'h1) n_last1++;
    check("t5_last_partials", 64'(n_last1), 64'(11));
    check("t5_count", 64'(obs.size()), 64'(110));

    // Reset mid-packet
    obs.delete();
    send(8'h50, 1'b0);
    send(8'h51, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_vld_o", 64'(bus.vld_o), 64'(1'b0));
    check("t6_data_o", 64'(bus.data_o), 64'(0));
    check("t6_strb_o", 64'(bus.strb_o), 64'(0));
    check("t6_sb_empty", 64'(sb.size()), 64'(0));
    mcnt = 0;
    macc = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(DW'(8'h10 + i), i == 3);
    drain("t6_drain");
    chk_beat("t6_word", 0, 32'h13121110, 4'hF, 1'b1);
    check("t6_count", 64'(obs.size()), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
